// File: rtl/soko_pkg.sv
// Shared types, default geometry and ROM stage images for the Sokoban stage loader.
package soko_pkg;

  typedef enum logic [1:0] {IDLE, FETCH, DRAIN, FINISH} state_e;

  localparam int GRID_W_DEF     = 8;
  localparam int GRID_H_DEF     = 8;
  localparam int NUM_STAGES_DEF = 4;

  // Field offsets inside one row word {box_row, dest_row, wall_row} at the default width.
  localparam int WALL_OFS = 0;
  localparam int DEST_OFS = GRID_W_DEF;
  localparam int BOX_OFS  = 2 * GRID_W_DEF;

  function automatic int scale_ofs(input int ofs, input int w);
    return (ofs / GRID_W_DEF) * w;
  endfunction

  function automatic int cell_idx(input int r, input int c, input int w);
    return r * w + c;
  endfunction

  // Stage images for an 8x8 grid; row r lives in byte r, column c at bit c of that byte.
  localparam int NUM_IMAGES = 4;
  localparam int IMG_SEL_W  = 2;

  localparam logic [63:0] WALL_IMG [NUM_IMAGES] = '{
    64'h3828_2fe1_87f4_141c,
    64'hff81_8181_8181_81ff,
    64'hff81_8181_8181_81ff,
    64'hffc3_8199_9981_c3ff
  };
  localparam logic [63:0] DEST_IMG [NUM_IMAGES] = '{
    64'h0010_0002_4000_0800,
    64'h0000_0000_2400_0000,
    64'h0000_0042_0000_0000,
    64'h0000_4000_0002_0000
  };
  localparam logic [63:0] BOX_IMG [NUM_IMAGES] = '{
    64'h0000_1004_2800_0000,
    64'h0000_0018_0000_0000,
    64'h0000_0000_1c00_0000,
    64'h0000_0400_0020_0000
  };
  localparam int PLAYER_X [NUM_IMAGES] = '{4, 1, 6, 5};
  localparam int PLAYER_Y [NUM_IMAGES] = '{4, 1, 6, 5};

endpackage

// File: rtl/level_rom.sv
// Registered-output level ROM addressed by {stage, idx}; idx < GRID_H gives a row word,
// idx == GRID_H gives the player entry {y, x}.
module level_rom
  import soko_pkg::*;
#(
  parameter int GRID_W     = GRID_W_DEF,
  parameter int GRID_H     = GRID_H_DEF,
  parameter int NUM_STAGES = NUM_STAGES_DEF,
  parameter int STAGE_W    = 2,
  parameter int X_W        = 3,
  parameter int Y_W        = 3,
  parameter int IDX_W      = $clog2(GRID_H + 1)
) (
  input  logic                  clk,
  input  logic [STAGE_W-1:0]    stage,
  input  logic [IDX_W-1:0]      idx,
  output logic [3*GRID_W-1:0]   data
);

  localparam int W_O = scale_ofs(WALL_OFS, GRID_W);
  localparam int D_O = scale_ofs(DEST_OFS, GRID_W);
  localparam int B_O = scale_ofs(BOX_OFS, GRID_W);

  logic [IMG_SEL_W-1:0] img;
  logic [3*GRID_W-1:0]  word;

  always_comb begin
    img  = IMG_SEL_W'(stage);
    word = '0;
    if (int'(stage) < NUM_STAGES && int'(stage) < NUM_IMAGES) begin
      if (int'(idx) < GRID_H) begin
        word[W_O +: GRID_W] = GRID_W'(WALL_IMG[img] >> (int'(idx) * GRID_W));
        word[D_O +: GRID_W] = GRID_W'(DEST_IMG[img] >> (int'(idx) * GRID_W));
        word[B_O +: GRID_W] = GRID_W'(BOX_IMG[img] >> (int'(idx) * GRID_W));
      end else if (int'(idx) == GRID_H) begin
        word[X_W-1:0]    = X_W'(PLAYER_X[img]);
        word[X_W +: Y_W] = Y_W'(PLAYER_Y[img]);
      end
    end
  end

  always_ff @(posedge clk) begin
    data <= word;
  end

endmodule

// File: rtl/level_loader.sv
// Sequential Sokoban stage loader: fetches one ROM row per cycle and assembles the level.
// Optional consistency check (box/destination counts, player cell) enabled by SOKO_STAGE_CHECK_EN.
module level_loader
  import soko_pkg::*;
#(
  parameter int GRID_W     = GRID_W_DEF,
  parameter int GRID_H     = GRID_H_DEF,
  parameter int NUM_STAGES = NUM_STAGES_DEF,
  parameter int STAGE_W    = 2,
  parameter int X_W        = 3,
  parameter int Y_W        = 3
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       start,
  input  logic [STAGE_W-1:0]         stage,
  output logic                       busy,
  output logic                       done,
  output logic                       stage_err,
  output logic                       level_valid,
  output logic [GRID_W*GRID_H-1:0]   wall,
  output logic [GRID_W*GRID_H-1:0]   destination,
  output logic [GRID_W*GRID_H-1:0]   box,
  output logic [X_W-1:0]             player_x,
  output logic [Y_W-1:0]             player_y,
  output logic                       level_bad
);

  localparam int IDX_W = $clog2(GRID_H + 1);
  localparam int N     = GRID_W * GRID_H;
  localparam int W_O   = scale_ofs(WALL_OFS, GRID_W);
  localparam int D_O   = scale_ofs(DEST_OFS, GRID_W);
  localparam int B_O   = scale_ofs(BOX_OFS, GRID_W);

  state_e               state_q, state_d;
  logic [STAGE_W-1:0]   stage_q, stage_d;
  logic [IDX_W-1:0]     idx_q, idx_d;
  logic                 rd_vld_q, rd_vld_d;
  logic [IDX_W-1:0]     rd_idx_q, rd_idx_d;
  logic [N-1:0]         wall_q, wall_d, dest_q, dest_d, box_q, box_d;
  logic [X_W-1:0]       px_q, px_d;
  logic [Y_W-1:0]       py_q, py_d;
  logic                 busy_q, busy_d, done_q, done_d;
  logic                 stage_err_q, stage_err_d, level_valid_q, level_valid_d;
  logic [3*GRID_W-1:0]  rom_data;
  logic [X_W-1:0]       rom_px;
  logic [Y_W-1:0]       rom_py;

  level_rom #(
    .GRID_W(GRID_W), .GRID_H(GRID_H), .NUM_STAGES(NUM_STAGES),
    .STAGE_W(STAGE_W), .X_W(X_W), .Y_W(Y_W), .IDX_W(IDX_W)
  ) u_rom (
    .clk  (clk),
    .stage(stage_q),
    .idx  (idx_q),
    .data (rom_data)
  );

  assign rom_px = rom_data[X_W-1:0];
  assign rom_py = rom_data[X_W +: Y_W];

`ifdef SOKO_STAGE_CHECK_EN
  localparam int CNT_W = $clog2(N + 1);

  logic [CNT_W-1:0] box_cnt_q, box_cnt_d, dest_cnt_q, dest_cnt_d;
  logic             level_bad_q, level_bad_d;
  logic [N-1:0]     wall_sh, box_sh;
  int               cell;

  function automatic logic [CNT_W-1:0] popcnt(input logic [GRID_W-1:0] row);
    return CNT_W'($countones(row));
  endfunction

  assign level_bad = level_bad_q;
`else
  assign level_bad = 1'b0;
`endif

  always_comb begin
    state_d       = state_q;
    stage_d       = stage_q;
    idx_d         = idx_q;
    rd_vld_d      = (state_q == FETCH);
    rd_idx_d      = idx_q;
    wall_d        = wall_q;
    dest_d        = dest_q;
    box_d         = box_q;
    px_d          = px_q;
    py_d          = py_q;
    busy_d        = busy_q;
    done_d        = 1'b0;
    stage_err_d   = 1'b0;
    level_valid_d = level_valid_q;
`ifdef SOKO_STAGE_CHECK_EN
    box_cnt_d   = box_cnt_q;
    dest_cnt_d  = dest_cnt_q;
    level_bad_d = level_bad_q;
    cell        = cell_idx(int'(rom_py), int'(rom_px), GRID_W);
    wall_sh     = wall_q >> cell;
    box_sh      = box_q >> cell;
`endif

    // ROM word issued last cycle lands here, tagged with the idx that produced it.
    if (rd_vld_q) begin
      if (rd_idx_q == IDX_W'(GRID_H)) begin
        px_d = rom_px;
        py_d = rom_py;
      end else begin
        for (int r = 0; r < GRID_H; r++) begin
          if (rd_idx_q == IDX_W'(r)) begin
            wall_d[r*GRID_W +: GRID_W] = rom_data[W_O +: GRID_W];
            dest_d[r*GRID_W +: GRID_W] = rom_data[D_O +: GRID_W];
            box_d[r*GRID_W +: GRID_W]  = rom_data[B_O +: GRID_W];
          end
        end
`ifdef SOKO_STAGE_CHECK_EN
        box_cnt_d  = box_cnt_q + popcnt(rom_data[B_O +: GRID_W]);
        dest_cnt_d = dest_cnt_q + popcnt(rom_data[D_O +: GRID_W]);
`endif
      end
    end

    case (state_q)
      IDLE: begin
        if (start) begin
          if (int'(stage) >= NUM_STAGES) begin
            stage_err_d = 1'b1;
          end else begin
            stage_d       = stage;
            idx_d         = '0;
            wall_d        = '0;
            dest_d        = '0;
            box_d         = '0;
            px_d          = '0;
            py_d          = '0;
            level_valid_d = 1'b0;
            busy_d        = 1'b1;
            state_d       = FETCH;
`ifdef SOKO_STAGE_CHECK_EN
            box_cnt_d   = '0;
            dest_cnt_d  = '0;
            level_bad_d = 1'b0;
`endif
          end
        end
      end
      FETCH: begin
        if (idx_q == IDX_W'(GRID_H)) begin
          state_d = DRAIN;
        end else begin
          idx_d = idx_q + 1'b1;
        end
      end
      DRAIN: begin
        state_d       = FINISH;
        done_d        = 1'b1;
        level_valid_d = 1'b1;
`ifdef SOKO_STAGE_CHECK_EN
        level_bad_d = (box_cnt_q != dest_cnt_q) || wall_sh[0] || box_sh[0];
`endif
      end
      FINISH: begin
        state_d = IDLE;
        busy_d  = 1'b0;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= IDLE;
      stage_q       <= '0;
      idx_q         <= '0;
      rd_vld_q      <= 1'b0;
      rd_idx_q      <= '0;
      wall_q        <= '0;
      dest_q        <= '0;
      box_q         <= '0;
      px_q          <= '0;
      py_q          <= '0;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
      stage_err_q   <= 1'b0;
      level_valid_q <= 1'b0;
`ifdef SOKO_STAGE_CHECK_EN
      box_cnt_q   <= '0;
      dest_cnt_q  <= '0;
      level_bad_q <= 1'b0;
`endif
    end else begin
      state_q       <= state_d;
      stage_q       <= stage_d;
      idx_q         <= idx_d;
      rd_vld_q      <= rd_vld_d;
      rd_idx_q      <= rd_idx_d;
      wall_q        <= wall_d;
      dest_q        <= dest_d;
      box_q         <= box_d;
      px_q          <= px_d;
      py_q          <= py_d;
      busy_q        <= busy_d;
      done_q        <= done_d;
      stage_err_q   <= stage_err_d;
      level_valid_q <= level_valid_d;
`ifdef SOKO_STAGE_CHECK_EN
      box_cnt_q   <= box_cnt_d;
      dest_cnt_q  <= dest_cnt_d;
      level_bad_q <= level_bad_d;
`endif
    end
  end

  assign busy        = busy_q;
  assign done        = done_q;
  assign stage_err   = stage_err_q;
  assign level_valid = level_valid_q;
  assign wall        = wall_q;
  assign destination = dest_q;
  assign box         = box_q;
  assign player_x    = px_q;
  assign player_y    = py_q;

endmodule

// File: tb/tb_level_loader.sv
// Bench for level_loader: table of stage loads checked through a scoreboard queue,
// plus hand-written sequences for ignored starts, mid-load reset and bad stage select.
`timescale 1ns/1ps
module tb_level_loader;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic        start, busy, done, stage_err, level_valid, level_bad;
  logic [1:0]  stage;
  logic [63:0] wall, destination, box;
  logic [2:0]  player_x, player_y;

  logic        start3, busy3, done3, stage_err3, level_valid3, level_bad3;
  logic [1:0]  stage3;
  logic [63:0] wall3, destination3, box3;
  logic [2:0]  player_x3, player_y3;

  level_loader #(.GRID_W(8), .GRID_H(8), .NUM_STAGES(4), .STAGE_W(2), .X_W(3), .Y_W(3)) dut (
    .clk(clk), .rst(rst), .start(start), .stage(stage), .busy(busy), .done(done),
    .stage_err(stage_err), .level_valid(level_valid), .wall(wall), .destination(destination),
    .box(box), .player_x(player_x), .player_y(player_y), .level_bad(level_bad)
  );

  level_loader #(.GRID_W(8), .GRID_H(8), .NUM_STAGES(3), .STAGE_W(2), .X_W(3), .Y_W(3)) dut3 (
    .clk(clk), .rst(rst), .start(start3), .stage(stage3), .busy(busy3), .done(done3),
    .stage_err(stage_err3), .level_valid(level_valid3), .wall(wall3), .destination(destination3),
    .box(box3), .player_x(player_x3), .player_y(player_y3), .level_bad(level_bad3)
  );

  typedef struct {
    int          stage;
    logic [63:0] wall;
    logic [63:0] dest;
    logic [63:0] box;
    int          px;
    int          py;
    bit          bad;
  } vec_t;

  vec_t img [4];
  vec_t tbl [5];
  vec_t sb [$];
  int   checks = 0;
  int   errors = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  function automatic bit model_bad(input vec_t v);
`ifdef SOKO_STAGE_CHECK_EN
    int cell = v.py * 8 + v.px;
    return ($countones(v.box) != $countones(v.dest)) ||
           (((v.wall >> cell) & 64'd1) != 64'd0) || (((v.box >> cell) & 64'd1) != 64'd0);
`else
    return (v.stage < 0);
`endif
  endfunction

  function automatic vec_t mk(input int s, input logic [63:0] w, input logic [63:0] d,
                              input logic [63:0] b, input int px, input int py);
    vec_t v;
    v.stage = s; v.wall = w; v.dest = d; v.box = b; v.px = px; v.py = py;
    v.bad = model_bad(v);
    return v;
  endfunction

  task automatic run_load(input vec_t v, input bit poke);
    int   cyc;
    bit   got;
    vec_t e;
    @(negedge clk);
    start = 1'b1;
    stage = 2'(v.stage);
    sb.push_back(v);
    @(negedge clk);
    start = 1'b0;
    cyc = 1;
    chk("valid_drop", 64'(level_valid), 64'd0);
    got = 1'b0;
    while (!got && cyc < 40) begin
      if (done) begin
        got = 1'b1;
      end else begin
        chk("busy_hold", 64'(busy), 64'd1);
        @(negedge clk);
        cyc++;
        start = poke && (cyc == 3 || cyc == 7);
      end
    end
    start = 1'b0;
    e = sb.pop_front();
    if (!got) begin
      chk("done_timeout", 64'd0, 64'd1);
    end else begin
      chk("done_cycle", 64'(cyc), 64'd11);
      chk("busy_at_done", 64'(busy), 64'd1);
      chk("valid_at_done", 64'(level_valid), 64'd1);
      chk("wall", wall, e.wall);
      chk("destination", destination, e.dest);
      chk("box", box, e.box);
      chk("player_x", 64'(player_x), 64'(e.px));
      chk("player_y", 64'(player_y), 64'(e.py));
      chk("level_bad", 64'(level_bad), 64'(e.bad));
    end
    @(negedge clk);
    chk("done_pulse", 64'(done), 64'd0);
    chk("busy_after", 64'(busy), 64'd0);
    chk("valid_hold", 64'(level_valid), 64'd1);
  endtask

  initial begin
    img[0] = mk(0, 64'h3828_2fe1_87f4_141c, 64'h0010_0002_4000_0800, 64'h0000_1004_2800_0000, 4, 4);
    img[1] = mk(1, 64'hff81_8181_8181_81ff, 64'h0000_0000_2400_0000, 64'h0000_0018_0000_0000, 1, 1);
    img[2] = mk(2, 64'hff81_8181_8181_81ff, 64'h0000_0042_0000_0000, 64'h0000_0000_1c00_0000, 6, 6);
    img[3] = mk(3, 64'hffc3_8199_9981_c3ff, 64'h0000_4000_0002_0000, 64'h0000_0400_0020_0000, 5, 5);
    tbl[0] = img[0];
    tbl[1] = img[1];
    tbl[2] = img[3];
    tbl[3] = img[2];
    tbl[4] = img[0];

    rst = 1'b1; start = 1'b0; stage = '0; start3 = 1'b0; stage3 = '0;
    #2;
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_done", 64'(done), 64'd0);
    chk("rst_valid", 64'(level_valid), 64'd0);
    chk("rst_wall", wall, 64'd0);
    chk("rst_player", 64'({player_y, player_x}), 64'd0);
    @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < 5; i++) run_load(tbl[i], 1'b0);

    // Starts pulsed while busy must be ignored.
    run_load(img[0], 1'b1);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("no_second_done", 64'(done), 64'd0);
      chk("no_restart", 64'(busy), 64'd0);
    end

    // Reset at cycle 5 of a load.
    @(negedge clk);
    start = 1'b1; stage = 2'd1;
    @(negedge clk);
    start = 1'b0;
    repeat (4) @(negedge clk);
    rst = 1'b1;
    #1;
    chk("mid_rst_busy", 64'(busy), 64'd0);
    chk("mid_rst_valid", 64'(level_valid), 64'd0);
    chk("mid_rst_wall", wall, 64'd0);
    chk("mid_rst_dest", destination, 64'd0);
    chk("mid_rst_box", box, 64'd0);
    chk("mid_rst_player", 64'({player_y, player_x}), 64'd0);
    chk("mid_rst_bad", 64'(level_bad), 64'd0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("post_rst_idle", 64'(busy), 64'd0);
    run_load(img[3], 1'b0);

    // Out-of-range stage on the three-stage instance.
    begin
      bit got3 = 1'b0;
      @(negedge clk);
      start3 = 1'b1; stage3 = 2'd1;
      @(negedge clk);
      start3 = 1'b0;
      for (int c = 0; c < 40 && !got3; c++) begin
        if (done3) got3 = 1'b1;
        else @(negedge clk);
      end
      chk("dut3_done_seen", 64'(got3), 64'd1);
      @(negedge clk);
      start3 = 1'b1; stage3 = 2'd3;
      @(negedge clk);
      start3 = 1'b0;
      chk("stage_err_pulse", 64'(stage_err3), 64'd1);
      chk("stage_err_busy", 64'(busy3), 64'd0);
      chk("stage_err_valid", 64'(level_valid3), 64'd1);
      chk("stage_err_wall", wall3, img[1].wall);
      chk("stage_err_box", box3, img[1].box);
      @(negedge clk);
      chk("stage_err_clear", 64'(stage_err3), 64'd0);
      chk("stage_err_idle", 64'(busy3), 64'd0);
      chk("stage_err_main", 64'(stage_err), 64'd0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/level_loader.md
Name: level_loader

Overview:
- Sequential stage loader for the Sokoban core. It replaces combinational stage decode with a parametrised, ROM-backed, row-by-row load.
- On a start request it fetches one grid row per cycle from an internal level ROM and assembles the wall, destination and box bitmaps plus the player position.
- It then presents the assembled level to the game logic with a valid/done handshake.

Parameters:
- GRID_W, 8, columns per row (bits per row bitmap)
- GRID_H, 8, rows per stage
- NUM_STAGES, 4, number of stages stored in the ROM
- STAGE_W, 2, width of the stage select; must satisfy 2**STAGE_W >= NUM_STAGES
- X_W, 3, player column width, $clog2(GRID_W)
- Y_W, 3, player row width, $clog2(GRID_H)

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  asynchronous, active-high reset
- start  in  1  load request; sampled only in IDLE
- stage  in  STAGE_W  stage to load; captured with start
- busy  out  1  high from the cycle after start is accepted until done
- done  out  1  one-cycle pulse when the level is complete
- stage_err  out  1  one-cycle pulse when start is received with stage >= NUM_STAGES
- level_valid  out  1  high while outputs hold a complete, loaded level
- wall  out  GRID_W*GRID_H  wall bitmap; row r at bits [r*GRID_W +: GRID_W], column c at bit c within the row
- destination  out  GRID_W*GRID_H  target bitmap, same layout
- box  out  GRID_W*GRID_H  initial box bitmap, same layout
- player_x  out  X_W  player column
- player_y  out  Y_W  player row
- level_bad  out  1  consistency flag (see Optional Feature)

Behaviour:
- Reset: state IDLE. All bitmaps 0; player_x, player_y 0; busy, done, stage_err, level_valid, level_bad 0. Reset mid-load aborts the load immediately and returns to these values.
- ROM organisation:
  - Address {stage, idx}, with idx in 0..GRID_H.
  - idx < GRID_H returns {box_row, dest_row, wall_row}, 3*GRID_W bits.
  - idx == GRID_H returns the player entry: {y, x} in the low X_W+Y_W bits, rest zero.
  - ROM read is registered, so data appears 1 cycle after the address.
- FSM states: IDLE, FETCH, DRAIN, FINISH.
  - IDLE, start=1, stage < NUM_STAGES: latch stage, clear level_valid, clear level_bad, zero all bitmaps, set idx=0, go to FETCH.
  - IDLE, start=1, stage >= NUM_STAGES: pulse stage_err the next cycle. No state change. Previous level and level_valid are untouched.
  - FETCH: issue address {stage, idx} and increment idx each cycle. After issuing idx == GRID_H, go to DRAIN.
  - DRAIN: consume the last ROM word, then go to FINISH.
  - Row data returning for idx k is written into bits [k*GRID_W +: GRID_W] of each bitmap. The player entry writes player_x and player_y.
  - FINISH: drive done=1 and level_valid=1 for one cycle, then return to IDLE.
- Latency: start sampled at cycle 0 gives done at cycle GRID_H+3, which is cycle 11 for the default 8x8.
- busy is 1 in FETCH, DRAIN and FINISH; 0 in IDLE.
- start while busy is ignored, not queued.
- level_valid stays 1 until the next accepted start or reset.
- A start arriving in the same cycle as the FINISH exit is ignored, because the FSM is not in IDLE.
- idx counter width is $clog2(GRID_H+1). It never wraps; FETCH exits at GRID_H.

Optional Feature:
- Macro SOKO_STAGE_CHECK_EN.
- When defined:
  - During row capture, accumulate popcount(box_row) and popcount(dest_row) in counters of width $clog2(GRID_W*GRID_H+1).
  - In FINISH, set level_bad=1 if box count != destination count, or the player cell is set in wall or box.
  - level_bad holds until the next accepted start.
- When undefined: level_bad is tied to 0 and no counters are built.

Decomposition:
- Shared package soko_pkg holds:
  - FSM state enum (IDLE, FETCH, DRAIN, FINISH)
  - default GRID_W/GRID_H/NUM_STAGES constants
  - row-word field offsets (WALL_OFS=0, DEST_OFS=GRID_W, BOX_OFS=2*GRID_W)
  - the cell-index helper function (r*GRID_W+c)
- Sub-module level_rom: registered-output ROM, address {stage, idx}, holds all stage contents.
- level_loader keeps the FSM, counters, assembly registers and the check logic.

Test Plan:
- Reset then start with stage=0 (8x8 defaults) -> busy high cycles 1..11, done pulse at cycle 11, level_valid=1. Outputs: wall=64'h3828_2fe1_87f4_141c, destination=64'h0010_0002_4000_0800, box=64'h0000_1004_2800_0000, player_x=4, player_y=4.
- Load stage 1, then stage 3 back-to-back after done -> second load's level_valid drops on its start; final outputs equal the stage-3 ROM image; no stale rows from stage 1.
- Pulse start again at cycles 3 and 7 while busy on stage 0 -> ignored; done still at cycle 11; exactly one done pulse.
- With NUM_STAGES=3, start with stage=3 -> stage_err pulse next cycle; busy stays 0; previous level and level_valid unchanged.
- Assert rst at cycle 5 of a load -> all outputs 0 and state IDLE on that edge; a fresh start loads correctly with done 11 cycles later.
- With SOKO_STAGE_CHECK_EN and a ROM stage holding 3 boxes and 2 destinations -> level_bad=1 with done. Same bench without the macro -> level_bad=0.
